// File: rtl/uart_reg_pkg.sv
// Shared constants and types for the UART register responder.
//   CMD_WR / CMD_RD : host command bytes (write frame, read frame)
//   RSP_OK / RSP_ERR: reply bytes (write acknowledge, unknown command)
//   ByteCntW        : width of the "reply bytes still to send" counter
//   state_e         : responder FSM states (SEND and GAP live in StWaitTx)
package uart_reg_pkg;

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h3F;

  localparam int unsigned ByteCntW = 2;

  typedef enum logic [2:0] {
    StIdle,
    StGetAddr,
    StGetData,
    StWrite,
    StRead,
    StReadCap,
    StWaitTx
  } state_e;

endpackage

// File: rtl/uart_reg_responder_if.sv
// Byte-link and register-bus bundle of the UART register responder.
//   rx_rec/rx_data    : UART receive flag (rising edge = new byte) and byte
//   tx_start/tx_data  : UART send request (core fires on rise) and byte
//   reg_addr/reg_wdata/reg_we/reg_re/reg_rdata : 32-bit register bus
//   busy              : responder is in the middle of a frame or reply
// slave modport is the responder side, master the UART core / bus side.
interface uart_reg_responder_if;

  logic        rx_rec;
  logic [7:0]  rx_data;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic [7:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_we;
  logic        reg_re;
  logic [31:0] reg_rdata;
  logic        busy;

  modport master (
    output rx_rec, rx_data, reg_rdata,
    input  tx_start, tx_data, reg_addr, reg_wdata, reg_we, reg_re, busy
  );

  modport slave (
    input  rx_rec, rx_data, reg_rdata,
    output tx_start, tx_data, reg_addr, reg_wdata, reg_we, reg_re, busy
  );

endinterface

// File: rtl/uart_tx_pacer.sv
// Transmit pacer: turns a one-cycle load into a UART send request.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   load_i        : start sending byte_i (registered, tx_start rises next cycle)
//   byte_i        : byte to send
//   tx_start_o    : high for TX_HOLD clocks from the rise
//   tx_data_o     : byte being sent, held until the next load
//   done_o        : one-cycle pulse on the last clock of the TX_GAP window; a load
//                   in that cycle puts the next rise exactly TX_GAP clocks later
module uart_tx_pacer #(
  parameter int unsigned TX_GAP  = 260,
  parameter int unsigned TX_HOLD = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic [7:0] byte_i,
  output logic       tx_start_o,
  output logic [7:0] tx_data_o,
  output logic       done_o
);

  localparam int unsigned GapW  = $clog2(TX_GAP + 1);
  localparam int unsigned HoldW = $clog2(TX_HOLD + 1);
  localparam logic [GapW-1:0]  GapMax  = GapW'(TX_GAP);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(TX_HOLD);

  logic             active_q, active_d;
  logic             start_q, start_d;
  logic [7:0]       data_q, data_d;
  logic [GapW-1:0]  gap_cnt_q, gap_cnt_d;
  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;

  // Counters hold 1 in the rise cycle, so gap_cnt == TX_GAP marks the last
  // clock before a new rise is allowed.
  assign done_o = active_q && (gap_cnt_q == GapMax);

  always_comb begin
    active_d   = active_q;
    start_d    = start_q;
    data_d     = data_q;
    gap_cnt_d  = gap_cnt_q;
    hold_cnt_d = hold_cnt_q;
    if (load_i) begin
      active_d   = 1'b1;
      start_d    = 1'b1;
      data_d     = byte_i;
      gap_cnt_d  = GapW'(1);
      hold_cnt_d = HoldW'(1);
    end else if (active_q) begin
      if (gap_cnt_q != GapMax) begin
        gap_cnt_d = gap_cnt_q + GapW'(1);
      end
      if (start_q) begin
        if (hold_cnt_q == HoldMax) begin
          start_d = 1'b0;
        end else begin
          hold_cnt_d = hold_cnt_q + HoldW'(1);
        end
      end
      if (done_o) begin
        active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      active_q   <= 1'b0;
      start_q    <= 1'b0;
      data_q     <= 8'h00;
      gap_cnt_q  <= '0;
      hold_cnt_q <= '0;
    end else begin
      active_q   <= active_d;
      start_q    <= start_d;
      data_q     <= data_d;
      gap_cnt_q  <= gap_cnt_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign tx_start_o = start_q;
  assign tx_data_o  = data_q;

endmodule

// File: rtl/uart_reg_responder.sv
// UART register-access responder.
//   sys_clk, sys_rst_n : clock, synchronous active-low reset
//   bus_io (slave)     : UART byte link in/out plus 32-bit register bus and busy
// Frames (MSB first): 57 addr d3 d2 d1 d0 -> write, reply 4B;
//                     52 addr             -> read, reply r3 r2 r1 r0;
//                     anything else       -> reply 3F.
// Bytes arriving while a frame is executed or a reply is sent are dropped.
module uart_reg_responder
  import uart_reg_pkg::*;
#(
  parameter int unsigned TX_GAP     = 260,
  parameter int unsigned TX_HOLD    = 4,
  parameter int unsigned RX_TIMEOUT = 50000
) (
  input logic                 sys_clk,
  input logic                 sys_rst_n,
  uart_reg_responder_if.slave bus_io
);

  localparam int unsigned ToW = $clog2(RX_TIMEOUT + 1);
  localparam logic [ToW-1:0] ToLast = ToW'(RX_TIMEOUT - 1);

  state_e                state_q, state_d;
  logic                  rx_rec_q;
  logic                  is_wr_q, is_wr_d;
  logic [7:0]            addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [1:0]            idx_q, idx_d;
  logic [ToW-1:0]        to_cnt_q, to_cnt_d;
  logic [31:0]           rsh_q, rsh_d;
  logic [ByteCntW-1:0]   rem_q, rem_d;

  logic       new_byte;
  logic       tx_load;
  logic [7:0] tx_byte;
  logic       tx_done;
  logic       reg_we, reg_re;

  // A level-high flag that stays up counts as a single byte.
  assign new_byte = bus_io.rx_rec & ~rx_rec_q;

  always_comb begin
    state_d  = state_q;
    is_wr_d  = is_wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    idx_d    = idx_q;
    to_cnt_d = to_cnt_q;
    rsh_d    = rsh_q;
    rem_d    = rem_q;
    tx_load  = 1'b0;
    tx_byte  = rsh_q[31:24];
    reg_we   = 1'b0;
    reg_re   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (new_byte) begin
          to_cnt_d = '0;
          if (bus_io.rx_data == CMD_WR) begin
            is_wr_d = 1'b1;
            state_d = StGetAddr;
          end else if (bus_io.rx_data == CMD_RD) begin
            is_wr_d = 1'b0;
            state_d = StGetAddr;
          end else begin
            tx_load = 1'b1;
            tx_byte = RSP_ERR;
            rem_d   = '0;
            state_d = StWaitTx;
          end
        end
      end
      StGetAddr: begin
        if (new_byte) begin
          addr_d   = bus_io.rx_data;
          to_cnt_d = '0;
          idx_d    = 2'd0;
          state_d  = is_wr_q ? StGetData : StRead;
        end else if (to_cnt_q == ToLast) begin
          state_d = StIdle;
        end else begin
          to_cnt_d = to_cnt_q + ToW'(1);
        end
      end
      StGetData: begin
        if (new_byte) begin
          wdata_d  = {wdata_q[23:0], bus_io.rx_data};
          to_cnt_d = '0;
          idx_d    = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = StWrite;
          end
        end else if (to_cnt_q == ToLast) begin
          state_d = StIdle;
        end else begin
          to_cnt_d = to_cnt_q + ToW'(1);
        end
      end
      StWrite: begin
        reg_we  = 1'b1;
        tx_load = 1'b1;
        tx_byte = RSP_OK;
        rem_d   = '0;
        state_d = StWaitTx;
      end
      StRead: begin
        reg_re  = 1'b1;
        state_d = StReadCap;
      end
      StReadCap: begin
        // First reply byte goes straight out; the rest wait in rsh.
        tx_load = 1'b1;
        tx_byte = bus_io.reg_rdata[31:24];
        rsh_d   = {bus_io.reg_rdata[23:0], 8'h00};
        rem_d   = ByteCntW'(3);
        state_d = StWaitTx;
      end
      StWaitTx: begin
        if (tx_done) begin
          if (rem_q != '0) begin
            tx_load = 1'b1;
            tx_byte = rsh_q[31:24];
            rsh_d   = {rsh_q[23:0], 8'h00};
            rem_d   = rem_q - ByteCntW'(1);
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q  <= StIdle;
      rx_rec_q <= 1'b0;
      is_wr_q  <= 1'b0;
      addr_q   <= 8'h00;
      wdata_q  <= 32'h0;
      idx_q    <= 2'd0;
      to_cnt_q <= '0;
      rsh_q    <= 32'h0;
      rem_q    <= '0;
    end else begin
      state_q  <= state_d;
      rx_rec_q <= bus_io.rx_rec;
      is_wr_q  <= is_wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      idx_q    <= idx_d;
      to_cnt_q <= to_cnt_d;
      rsh_q    <= rsh_d;
      rem_q    <= rem_d;
    end
  end

  uart_tx_pacer #(
    .TX_GAP (TX_GAP),
    .TX_HOLD(TX_HOLD)
  ) u_pacer (
    .clk_i     (sys_clk),
    .rst_ni    (sys_rst_n),
    .load_i    (tx_load),
    .byte_i    (tx_byte),
    .tx_start_o(bus_io.tx_start),
    .tx_data_o (bus_io.tx_data),
    .done_o    (tx_done)
  );

  assign bus_io.reg_addr  = addr_q;
  assign bus_io.reg_wdata = wdata_q;
  assign bus_io.reg_we    = reg_we;
  assign bus_io.reg_re    = reg_re;
  assign bus_io.busy      = (state_q != StIdle);

endmodule
